step_sequencer: RTL

- Parametrised forward/back/clear step state machine. It is the generalised successor of the 4-position A/B/C/D stepper.
- Position count, end-of-range mode (saturate or wrap) and input qualification (level or rising edge) are configurable.
- Adds a synchronous load, boundary flags and a wrap pulse.
- Sits between debounced button/control inputs and display or mux-select logic.

---
 rtl/step_pkg.sv | 28 ++
 rtl/step_sequencer_edge_rise.sv | 36 +++
 rtl/step_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/step_pkg.sv
`default_nettype none
// ============================================================================
// Module      : step_pkg
// Description : Shared constants, types and helpers for the step sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package step_pkg;

    localparam int WRAP_SATURATE = 0;
    localparam int WRAP_AROUND   = 1;
    localparam int MODE_LEVEL    = 0;
    localparam int MODE_EDGE     = 1;

    typedef enum logic [2:0] {
        ACT_HOLD    = 3'd0,
        ACT_CLEAR   = 3'd1,
        ACT_LOAD    = 3'd2,
        ACT_RECOVER = 3'd3,
        ACT_FWD     = 3'd4,
        ACT_BACK    = 3'd5
    } step_act_e;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/step_sequencer_edge_rise.sv
`default_nettype none
// ============================================================================
// Module      : edge_rise
// Description : 1-bit rising-edge qualifier; BYPASS passes the level through.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_rise #(
    parameter bit BYPASS = 1'b0
) (
    input  logic iClk,
    input  logic iReset,
    input  logic iSignal,
    output logic oRise
);

    generate
        if (BYPASS) begin : g_level
            assign oRise = iSignal;
        end else begin : g_edge
            logic rPrev;

            // History updates every cycle, even when the request is overridden
            always_ff @(posedge iClk or posedge iReset) begin
                if (iReset) begin
                    rPrev <= 1'b0;
                end else begin
                    rPrev <= iSignal;
                end
            end

            assign oRise = iSignal & ~rPrev;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/step_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : step_sequencer
// Description : Parametrised forward/back/clear/load position stepper.
// Revision    : 1.0 - initial release
// ============================================================================
module step_sequencer
    import step_pkg::*;
#(
    parameter int NUM_STATES  = 4,
    parameter int WIDTH       = clog2_min1(NUM_STATES),
    parameter int WRAP_EN     = WRAP_SATURATE,
    parameter int EDGE_DETECT = MODE_EDGE
) (
    input  logic             iClk,
    input  logic             iReset,
    input  logic             iClear,
    input  logic             iLoad,
    input  logic [WIDTH-1:0] iLoadValue,
    input  logic             iForward,
    input  logic             iBack,
    output logic [WIDTH-1:0] oStateValue,
    output logic             oAtMin,
    output logic             oAtMax,
    output logic             oWrapped
);

    localparam logic [WIDTH-1:0] MAX_POS = WIDTH'(NUM_STATES - 1);
    localparam bit               BYPASS  = (EDGE_DETECT == MODE_LEVEL);

    logic [WIDTH-1:0] rState;
    logic             rWrapped;
    logic [WIDTH-1:0] wNext;
    logic             wWrapNext;
    logic [WIDTH-1:0] wLoadClamped;
    logic             wIllegal;
    logic             wFwdQual;
    logic             wBackQual;
    step_act_e        wAct;

    edge_rise #(.BYPASS(BYPASS)) uFwdEdge (
        .iClk    (iClk),
        .iReset  (iReset),
        .iSignal (iForward),
        .oRise   (wFwdQual)
    );

    edge_rise #(.BYPASS(BYPASS)) uBackEdge (
        .iClk    (iClk),
        .iReset  (iReset),
        .iSignal (iBack),
        .oRise   (wBackQual)
    );

    // With a power-of-two range every code is legal and nothing needs clamping
    generate
        if (NUM_STATES == (1 << WIDTH)) begin : g_full_range
            assign wIllegal     = 1'b0;
            assign wLoadClamped = iLoadValue;
        end else begin : g_partial_range
            assign wIllegal     = (rState > MAX_POS);
            assign wLoadClamped = (iLoadValue > MAX_POS) ? MAX_POS : iLoadValue;
        end
    endgenerate

    always_comb begin
        wAct = ACT_HOLD;
        if (iClear) begin
            wAct = ACT_CLEAR;
        end else if (iLoad) begin
            wAct = ACT_LOAD;
        end else if (wIllegal) begin
            wAct = ACT_RECOVER;
        end else if (wFwdQual) begin
            wAct = ACT_FWD;
        end else if (wBackQual) begin
            wAct = ACT_BACK;
        end
    end

    // Boundaries are tested before the arithmetic so no illegal code is produced
    always_comb begin
        wNext     = rState;
        wWrapNext = 1'b0;
        case (wAct)
            ACT_CLEAR, ACT_RECOVER: wNext = '0;
            ACT_LOAD:               wNext = wLoadClamped;
            ACT_FWD: begin
                if (rState == MAX_POS) begin
                    if (WRAP_EN == WRAP_AROUND) begin
                        wNext     = '0;
                        wWrapNext = 1'b1;
                    end
                end else begin
                    wNext = rState + WIDTH'(1);
                end
            end
            ACT_BACK: begin
                if (rState == '0) begin
                    if (WRAP_EN == WRAP_AROUND) begin
                        wNext     = MAX_POS;
                        wWrapNext = 1'b1;
                    end
                end else begin
                    wNext = rState - WIDTH'(1);
                end
            end
            default: wNext = rState;
        endcase
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            rState   <= '0;
            rWrapped <= 1'b0;
        end else begin
            rState   <= wNext;
            rWrapped <= wWrapNext;
        end
    end

    assign oStateValue = rState;
    assign oWrapped    = rWrapped;
    assign oAtMin      = (rState == '0);
    assign oAtMax      = (rState == MAX_POS);

endmodule
`default_nettype wire
